// File: rtl/sync_down_counter_pkg.sv
// -----------------------------------------------------------------------------
// sync_down_counter_pkg
//
// Purpose:
//    Shared types and constants for the programmable down counter and its
//    toggle flip-flop slice. It holds the controller state encodings, the
//    width of the state register, and the selector used to choose what the
//    count register does on the next edge.
//
// Contents:
//    STATE_W       width of the controller state register
//    CounterState  IDLE / RUN / DONE controller states
//    QMode         next-edge action for the count register
// -----------------------------------------------------------------------------
package sync_down_counter_pkg;

   // Two bits cover the three controller states.
   localparam int STATE_W = 2;

   // Controller states. The encodings are fixed so other blocks in the
   // datapath/control can decode them if they ever need to.
   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } CounterState;

   // Action applied to the count register on the next clock edge.
   //    QM_HOLD   : keep the current count
   //    QM_DEC    : subtract one by using the borrow chain
   //    QM_LOAD_D : take the parallel load value D
   //    QM_LOAD_R : take the captured reload value
   typedef enum logic [1:0] {
      QM_HOLD   = 2'd0,
      QM_DEC    = 2'd1,
      QM_LOAD_D = 2'd2,
      QM_LOAD_R = 2'd3
   } QMode;

endpackage : sync_down_counter_pkg

// File: rtl/sync_down_counter_tff_async_clear.sv
// -----------------------------------------------------------------------------
// tff_async_clear
//
// Purpose:
//    One bit of the down counter. It is a toggle flip-flop: when T is high on
//    a rising clock edge, the stored bit inverts. When T is low, the bit holds.
//    A low level on CLR_N forces the bit to 0 at once, without waiting for a
//    clock edge.
//
// Ports:
//    CLK    in   1  clock, state changes on posedge
//    CLR_N  in   1  asynchronous active-low clear
//    T      in   1  toggle enable
//    Q      out  1  stored bit
// -----------------------------------------------------------------------------
module tff_async_clear (
   input  logic CLK,
   input  logic CLR_N,
   input  logic T,
   output logic Q
);

   // The bit only ever toggles. The parent turns a load into a toggle
   // request by XORing the present value with the wanted value.
   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         Q <= 1'b0;
      end else if (T) begin
         Q <= ~Q;
      end
   end

endmodule : tff_async_clear

// File: rtl/sync_down_counter.sv
// -----------------------------------------------------------------------------
// sync_down_counter
//
// Purpose:
//    Programmable synchronous down counter / countdown timer. It counts from a
//    loaded value toward zero and raises a registered terminal-count flag when
//    the count reaches zero. It supports a single-shot mode and an
//    auto-reload (periodic) mode. It is used for delay and timeout sequencing
//    in the MIPS datapath/control.
//
// Parameters:
//    N            counter width in bits (N >= 2)
//
// Ports:
//    CLK          in   1  clock, all state updates on posedge
//    CLR_N        in   1  asynchronous active-low clear
//    LOAD         in   1  parallel load strobe
//    D            in   N  load value, also captured as the reload value
//    START        in   1  start/resume strobe
//    STOP         in   1  pause strobe
//    AUTO_RELOAD  in   1  1 = periodic mode, 0 = single-shot
//    Q            out  N  current count
//    TC           out  1  terminal-count flag, registered
//    BUSY         out  1  high while the controller is in RUN
//    DONE         out  1  high while the controller is in DONE
// -----------------------------------------------------------------------------
module sync_down_counter
   import sync_down_counter_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         CLK,
   input  logic         CLR_N,
   input  logic         LOAD,
   input  logic [N-1:0] D,
   input  logic         START,
   input  logic         STOP,
   input  logic         AUTO_RELOAD,
   output logic [N-1:0] Q,
   output logic         TC,
   output logic         BUSY,
   output logic         DONE
);

   CounterState state;
   CounterState stateNext;
   QMode        qMode;
   logic [N-1:0] reloadVal;
   logic [N-1:0] reloadNext;
   logic         tcReg;
   logic         tcNext;
   logic         qIsZero;
   logic         qIsOne;
   logic         reloadIsZero;
   logic [N-1:0] borrow;
   logic [N-1:0] loadVal;
   logic [N-1:0] toggle;

   // These count decodes are shared by the controller and the toggle logic.
   // The comparisons are written so they stay correct for any width N.
   always_comb begin
      qIsZero      = (Q == '0);
      qIsOne       = (Q == {{(N-1){1'b0}}, 1'b1});
      reloadIsZero = (reloadVal == '0);
   end

   // Controller next-state logic. A strobe is acted on only in a state where
   // it means something, and the priority is LOAD, then STOP, then START.
   // STOP takes the edge even where it is ignored, so a STOP+START pair never
   // starts the counter. Every output starts from "hold, no TC". Each branch
   // changes only what differs from that default.
   always_comb begin
      stateNext  = state;
      qMode      = QM_HOLD;
      tcNext     = 1'b0;
      reloadNext = reloadVal;

      if (LOAD) begin
         qMode      = QM_LOAD_D;
         reloadNext = D;
         stateNext  = ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (!STOP && START) begin
                  if (qIsZero) begin
                     stateNext = ST_DONE;
                     tcNext    = 1'b1;
                  end else begin
                     stateNext = ST_RUN;
                  end
               end
            end

            ST_RUN: begin
               if (STOP) begin
                  stateNext = ST_IDLE;
               end else if (qIsOne) begin
                  qMode  = QM_DEC;
                  tcNext = 1'b1;
                  if (!AUTO_RELOAD) begin
                     stateNext = ST_DONE;
                  end
               end else if (qIsZero) begin
                  // RUN sees a zero count only in periodic mode, in the cycle
                  // after the terminal pulse. If periodic mode was dropped
                  // at that moment, the run ends here without a second pulse.
                  if (AUTO_RELOAD) begin
                     qMode  = QM_LOAD_R;
                     tcNext = reloadIsZero;
                  end else begin
                     stateNext = ST_DONE;
                  end
               end else begin
                  qMode = QM_DEC;
               end
            end

            ST_DONE: begin
               if (!STOP && START) begin
                  qMode = QM_LOAD_R;
                  if (reloadIsZero) begin
                     tcNext = 1'b1;
                  end else begin
                     stateNext = ST_RUN;
                  end
               end
            end

            default: begin
               stateNext = ST_IDLE;
            end
         endcase
      end
   end

   // Borrow chain for the decrement. Bit i flips when every lower bit is
   // zero. The chain is gated by a non-zero count, so the counter can never
   // wrap from zero to all ones.
   always_comb begin
      borrow[0] = ~qIsZero;
      for (int i = 1; i < N; i++) begin
         borrow[i] = borrow[i-1] & ~Q[i-1];
      end
   end

   // Toggle requests for the flip-flop slice. A load becomes "flip every bit
   // that differs from the target". A decrement uses the borrow chain.
   always_comb begin
      loadVal = (qMode == QM_LOAD_R) ? reloadVal : D;
      toggle  = '0;
      unique case (qMode)
         QM_DEC:    toggle = borrow;
         QM_LOAD_D: toggle = Q ^ loadVal;
         QM_LOAD_R: toggle = Q ^ loadVal;
         default:   toggle = '0;
      endcase
   end

   // One toggle flip-flop per count bit.
   for (genvar g = 0; g < N; g++) begin : gBit
      tff_async_clear uBit (
         .CLK   (CLK),
         .CLR_N (CLR_N),
         .T     (toggle[g]),
         .Q     (Q[g])
      );
   end

   // Controller state, reload value and terminal-count flag. A clear resets
   // all three at once, together with the count bits.
   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         state     <= ST_IDLE;
         reloadVal <= '0;
         tcReg     <= 1'b0;
      end else begin
         state     <= stateNext;
         reloadVal <= reloadNext;
         tcReg     <= tcNext;
      end
   end

   // The status outputs are a straight decode of the registered state.
   always_comb begin
      TC   = tcReg;
      BUSY = (state == ST_RUN);
      DONE = (state == ST_DONE);
   end

endmodule : sync_down_counter

// File: tb/tb_sync_down_counter.sv
// -----------------------------------------------------------------------------
// tb_sync_down_counter
//
// Purpose:
//    Directed bench for sync_down_counter with N=4. The stimulus side
//    drives one vector per cycle and queues the hand-computed response for
//    that cycle. A separate monitor pops the queue on each falling edge and
//    compares the queued values against the counter outputs.
// -----------------------------------------------------------------------------
module tb_sync_down_counter;

   logic       CLK;
   logic       CLR_N;
   logic       LOAD;
   logic [3:0] D;
   logic       START;
   logic       STOP;
   logic       AUTO_RELOAD;
   logic [3:0] Q;
   logic       TC;
   logic       BUSY;
   logic       DONE;

   typedef struct {
      logic [3:0] q;
      logic       tc;
      logic       busy;
      logic       done;
      string      name;
   } ExpEntry;

   ExpEntry expQueue[$];
   int      checks = 0;
   int      errors = 0;
   event    sampleNow;

   sync_down_counter #(.N(4)) dut (
      .CLK         (CLK),
      .CLR_N       (CLR_N),
      .LOAD        (LOAD),
      .D           (D),
      .START       (START),
      .STOP        (STOP),
      .AUTO_RELOAD (AUTO_RELOAD),
      .Q           (Q),
      .TC          (TC),
      .BUSY        (BUSY),
      .DONE        (DONE)
   );

   // Free-running clock with a 10-unit period.
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Compare one queued expectation with the outputs as they are now.
   task automatic checkOutput(input ExpEntry e);
      checks++;
      if ({Q, TC, BUSY, DONE} !== {e.q, e.tc, e.busy, e.done}) begin
         errors++;
         $display("[TB] FAIL %s: got Q=%0d TC=%b BUSY=%b DONE=%b, expected Q=%0d TC=%b BUSY=%b DONE=%b",
                  e.name, Q, TC, BUSY, DONE, e.q, e.tc, e.busy, e.done);
      end
   endtask

   // Monitor: drain the queue on every falling edge, and also on request
   // when a check must happen between clock edges.
   initial begin
      forever begin
         @(negedge CLK or sampleNow);
         while (expQueue.size() > 0) begin
            checkOutput(expQueue.pop_front());
         end
      end
   end

   // Drive one vector, let it take effect on the next rising edge, then
   // queue the values expected after that edge.
   task automatic applyStimulus(input logic ld, input logic [3:0] dv,
                                input logic st, input logic sp, input logic ar,
                                input logic [3:0] eq, input logic etc,
                                input logic eb, input logic ed, input string nm);
      ExpEntry e;
      LOAD        = ld;
      D           = dv;
      START       = st;
      STOP        = sp;
      AUTO_RELOAD = ar;
      @(posedge CLK);
      e.q = eq; e.tc = etc; e.busy = eb; e.done = ed; e.name = nm;
      expQueue.push_back(e);
      #1;
   endtask

   // Pull the clear low between edges and check that everything is zero
   // before the next rising edge. Then hold the clear through one edge and
   // release it.
   task automatic applyClear(input string nm);
      ExpEntry e;
      LOAD = 1'b0; D = 4'd0; START = 1'b0; STOP = 1'b0; AUTO_RELOAD = 1'b0;
      @(negedge CLK);
      #1;
      CLR_N = 1'b0;
      #1;
      e.q = 4'd0; e.tc = 1'b0; e.busy = 1'b0; e.done = 1'b0; e.name = nm;
      expQueue.push_back(e);
      -> sampleNow;
      @(posedge CLK);
      e.name = {nm, "_held"};
      expQueue.push_back(e);
      #1;
      CLR_N = 1'b1;
   endtask

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      ExpEntry rst;
      logic [3:0] ev;

      // Test 1: hold the clear for two cycles, then release it.
      CLR_N = 1'b0;
      LOAD = 1'b0; D = 4'd0; START = 1'b0; STOP = 1'b0; AUTO_RELOAD = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      rst.q = 4'd0; rst.tc = 1'b0; rst.busy = 1'b0; rst.done = 1'b0; rst.name = "reset";
      expQueue.push_back(rst);
      @(negedge CLK);
      #1;
      CLR_N = 1'b1;
      @(posedge CLK);
      #1;
      applyStimulus(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0, "post_reset_idle");

      // Test 2: single-shot count from 10.
      applyStimulus(1, 4'd10, 0, 0, 0, 4'd10, 0, 0, 0, "load10");
      applyStimulus(0, 4'd0, 1, 0, 0, 4'd10, 0, 1, 0, "start10");
      for (int k = 9; k >= 1; k--) begin
         applyStimulus(0, 4'd0, 0, 0, 0, 4'(k), 0, 1, 0, "count10");
      end
      applyStimulus(0, 4'd0, 0, 0, 0, 4'd0, 1, 0, 1, "tc10");
      applyStimulus(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1, "done10_hold");

      // Test 3: periodic mode with reload 3, then drop periodic mode.
      applyStimulus(1, 4'd3, 0, 0, 1, 4'd3, 0, 0, 0, "load3_auto");
      applyStimulus(0, 4'd0, 1, 0, 1, 4'd3, 0, 1, 0, "start3_auto");
      for (int i = 1; i <= 8; i++) begin
         ev = 4'(3 - (i % 4));
         applyStimulus(0, 4'd0, 0, 0, 1, ev, (ev == 4'd0), 1, 0, "auto3");
      end
      applyStimulus(0, 4'd0, 0, 0, 0, 4'd2, 0, 1, 0, "auto_off_2");
      applyStimulus(0, 4'd0, 0, 0, 0, 4'd1, 0, 1, 0, "auto_off_1");
      applyStimulus(0, 4'd0, 0, 0, 0, 4'd0, 1, 0, 1, "auto_off_final");
      applyStimulus(0, 4'd0, 1, 0, 0, 4'd3, 0, 1, 0, "done_restart_reload");
      applyStimulus(0, 4'd0, 0, 1, 0, 4'd3, 0, 0, 0, "stop_after_restart");

      // Test 4: pause at 6, stay idle, then resume. START while running is ignored.
      applyStimulus(1, 4'd10, 0, 0, 0, 4'd10, 0, 0, 0, "load10_b");
      applyStimulus(0, 4'd0, 1, 0, 0, 4'd10, 0, 1, 0, "start10_b");
      for (int k = 9; k >= 6; k--) begin
         applyStimulus(0, 4'd0, 0, 0, 0, 4'(k), 0, 1, 0, "count_to6");
      end
      applyStimulus(0, 4'd0, 0, 1, 0, 4'd6, 0, 0, 0, "stop_at6");
      for (int k = 0; k < 4; k++) begin
         applyStimulus(0, 4'd0, 0, 0, 0, 4'd6, 0, 0, 0, "paused6");
      end
      applyStimulus(0, 4'd0, 1, 0, 0, 4'd6, 0, 1, 0, "resume6");
      applyStimulus(0, 4'd0, 0, 0, 0, 4'd5, 0, 1, 0, "resumed5");
      applyStimulus(0, 4'd0, 0, 0, 0, 4'd4, 0, 1, 0, "resumed4");
      applyStimulus(0, 4'd0, 1, 0, 0, 4'd3, 0, 1, 0, "start_in_run_ignored");

      // Test 5: LOAD and START on the same edge. LOAD wins.
      applyStimulus(1, 4'd5, 1, 0, 0, 4'd5, 0, 0, 0, "load5_start");
      applyStimulus(0, 4'd0, 1, 0, 0, 4'd5, 0, 1, 0, "start5");
      applyStimulus(0, 4'd0, 0, 0, 0, 4'd4, 0, 1, 0, "count5_4");

      // Test 6: full-range count with no wrap, then zero-load cases.
      applyStimulus(1, 4'd15, 0, 0, 0, 4'd15, 0, 0, 0, "load15");
      applyStimulus(0, 4'd0, 1, 0, 0, 4'd15, 0, 1, 0, "start15");
      for (int k = 14; k >= 1; k--) begin
         applyStimulus(0, 4'd0, 0, 0, 0, 4'(k), 0, 1, 0, "count15");
      end
      applyStimulus(0, 4'd0, 0, 0, 0, 4'd0, 1, 0, 1, "tc15");
      applyStimulus(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1, "no_wrap");
      applyStimulus(0, 4'd0, 0, 1, 0, 4'd0, 0, 0, 1, "stop_in_done_ignored");
      applyStimulus(1, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0, "load0");
      applyStimulus(0, 4'd0, 1, 0, 0, 4'd0, 1, 0, 1, "start0_done_pulse");
      applyStimulus(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1, "done0_hold");
      applyStimulus(0, 4'd0, 1, 0, 0, 4'd0, 1, 0, 1, "restart_reload0");
      applyStimulus(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1, "done0_hold2");

      // Clear in the middle of a count at Q=7.
      applyStimulus(1, 4'd10, 0, 0, 0, 4'd10, 0, 0, 0, "load10_c");
      applyStimulus(0, 4'd0, 1, 0, 0, 4'd10, 0, 1, 0, "start10_c");
      for (int k = 9; k >= 7; k--) begin
         applyStimulus(0, 4'd0, 0, 0, 0, 4'(k), 0, 1, 0, "count_to7");
      end
      applyClear("clear_mid_run");
      // With the reload value cleared, a START from zero goes to DONE, and a
      // second START stays in DONE.
      applyStimulus(0, 4'd0, 1, 0, 0, 4'd0, 1, 0, 1, "start_after_clear");
      applyStimulus(0, 4'd0, 1, 0, 0, 4'd0, 1, 0, 1, "reload_cleared");
      applyStimulus(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1, "final_hold");

      // Let the monitor drain, then confirm nothing was left unchecked.
      @(negedge CLK);
      #1;
      checks++;
      if (expQueue.size() != 0) begin
         errors++;
         $display("[TB] FAIL queue_drain: got %0d pending, expected 0", expQueue.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_sync_down_counter
